ctrl_sequencer: RTL and testbench

Multi-cycle control sequencer for the accumulator datapath. It fetches 9-bit instructions, drives the ALU operation select and register-file/accumulator write controls, and latches the ALU zero flag for conditional branches. It runs load/store handshakes with data memory. It sits between the instruction ROM and the ALU, and is the control-side producer of the 3-bit ALU op code and the consumer of the zero signal.

---
 rtl/ctrl_sequencer_pkg.sv | 47 ++++
 rtl/ctrl_sequencer_if.sv | 9 +
 rtl/ctrl_sequencer_inst_decode.sv | 47 ++++
 rtl/ctrl_sequencer.sv | 147 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the accumulator-datapath control sequencer:
// ALU op codes, FSM state codes, opcode classes, write-back select and decode fields.
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLL = 3'd2,
    ALU_SRL = 3'd3,
    ALU_EQU = 3'd4,
    ALU_GTR = 3'd5,
    ALU_AND = 3'd6,
    ALU_XOR = 3'd7
  } alu_op_e;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // ir[8:6] classes when ir[8] is clear
  localparam logic [2:0] CLS_MOVR = 3'b000;
  localparam logic [2:0] CLS_MOVA = 3'b001;
  localparam logic [2:0] CLS_BRZ  = 3'b010;
  localparam logic [2:0] CLS_MEM  = 3'b011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_ACC = 2'd1;
  localparam logic [1:0] WB_REG = 2'd2;
  localparam logic [1:0] WB_MEM = 2'd3;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [3:0] addr;
    logic [5:0] br_off;
    logic       is_sub;
    logic       is_brz;
    logic       is_ld;
    logic       is_st;
    logic       is_halt;
    logic       acc_we;
    logic       reg_we;
    logic [1:0] wb_sel;
  } dec_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Data-memory load/store handshake between the sequencer (master) and memory (slave).
interface ctrl_sequencer_if;
  logic mem_req_out;
  logic mem_we_out;
  logic mem_ack_in;

  modport master (output mem_req_out, output mem_we_out, input mem_ack_in);
  modport slave  (input mem_req_out, input mem_we_out, output mem_ack_in);
endinterface

// File: rtl/ctrl_sequencer_inst_decode.sv
// Combinational instruction decode: maps the 9-bit instruction register to control fields.
module ctrl_sequencer_inst_decode
  import ctrl_sequencer_pkg::*;
(
  input  logic [8:0] ir_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ir_i[7:5];
    dec_o.addr   = ir_i[3:0];
    dec_o.br_off = ir_i[5:0];
    if (ir_i[8]) begin
      dec_o.is_sub = (ir_i[7:5] == ALU_SUB);
      dec_o.reg_we = ir_i[4];
      dec_o.acc_we = ~ir_i[4];
      dec_o.wb_sel = WB_ALU;
    end else begin
      case (ir_i[8:6])
        CLS_MOVR: begin
          dec_o.reg_we = 1'b1;
          dec_o.wb_sel = WB_ACC;
        end
        CLS_MOVA: begin
          dec_o.acc_we = 1'b1;
          dec_o.wb_sel = WB_REG;
        end
        CLS_BRZ: dec_o.is_brz = 1'b1;
        CLS_MEM: begin
          // ir[4] marks HALT and takes priority over the LD/ST selector
          if (ir_i[4]) begin
            dec_o.is_halt = 1'b1;
          end else if (ir_i[5]) begin
            dec_o.is_st  = 1'b1;
            dec_o.wb_sel = WB_ACC;
          end else begin
            dec_o.is_ld  = 1'b1;
            dec_o.wb_sel = WB_MEM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: FETCH/EXEC/MEM FSM, pc, zero flag and write controls.
// Optional MEM_TIMEOUT_EN: abandon a load/store after 16 unacknowledged MEM cycles.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        inst_in,
  output logic [PC_W-1:0]   pc_out,
  output logic [2:0]        alu_op_out,
  input  logic              zero_in,
  output logic [3:0]        reg_addr_out,
  output logic              reg_we_out,
  output logic              acc_we_out,
  output logic [1:0]        wb_sel_out,
  ctrl_sequencer_if.master  mem,
  output logic              done_out,
  output logic              err_out
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            zflag_q, zflag_d;
  logic [PC_W-1:0] br_ext;
  logic            restart;
  logic            tmo_hit;
  dec_t            dec;

  ctrl_sequencer_inst_decode u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign br_ext  = {{(PC_W-6){dec.br_off[5]}}, dec.br_off};
  assign restart = start && ((state_q == S_IDLE) || (state_q == S_HALT));

`ifdef MEM_TIMEOUT_EN
  logic [3:0] tmo_q, tmo_d;
  logic       err_q, err_d;

  // Counter is zero on MEM entry because it only advances while in MEM
  assign tmo_hit = (state_q == S_MEM) && !mem.mem_ack_in && (tmo_q == 4'hf);

  always_comb begin
    tmo_d = (state_q == S_MEM) ? tmo_q + 4'd1 : 4'd0;
    err_d = err_q;
    if (restart)      err_d = 1'b0;
    else if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zflag_d = zflag_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          zflag_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = inst_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec.is_sub) zflag_d = zero_in;
        if (dec.is_halt) begin
          state_d = S_HALT;
        end else if (dec.is_ld || dec.is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          pc_d    = (dec.is_brz && zflag_q) ? pc_q + br_ext : pc_q + PC_W'(1);
        end
      end
      S_MEM: begin
        if (mem.mem_ack_in) begin
          state_d = S_FETCH;
          pc_d    = pc_q + PC_W'(1);
        end else if (tmo_hit) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zflag_q <= zflag_d;
    end
  end

  assign pc_out          = pc_q;
  assign alu_op_out      = dec.alu_op;
  assign reg_addr_out    = dec.addr;
  assign done_out        = (state_q == S_HALT);
  assign mem.mem_req_out = (state_q == S_MEM);
  assign mem.mem_we_out  = (state_q == S_MEM) && dec.is_st;

  // The load write is qualified by ack so it lands on the cycle the memory data is valid
  always_comb begin
    reg_we_out = 1'b0;
    acc_we_out = 1'b0;
    wb_sel_out = WB_ALU;
    if (state_q == S_EXEC) begin
      reg_we_out = dec.reg_we;
      acc_we_out = dec.acc_we;
      wb_sel_out = dec.wb_sel;
    end else if ((state_q == S_MEM) && dec.is_ld) begin
      acc_we_out = mem.mem_ack_in;
      wb_sel_out = WB_MEM;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed vector table, multi-cycle corner sequences,
// then randomized instructions against an instruction-level reference model.
module tb_ctrl_sequencer;

  logic       clk, rst_n, start, zero_in;
  logic [8:0] inst_in;
  logic [7:0] pc_out;
  logic [2:0] alu_op_out;
  logic [3:0] reg_addr_out;
  logic       reg_we_out, acc_we_out, done_out, err_out;
  logic [1:0] wb_sel_out;

  ctrl_sequencer_if mif();

  ctrl_sequencer #(.PC_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .inst_in      (inst_in),
    .pc_out       (pc_out),
    .alu_op_out   (alu_op_out),
    .zero_in      (zero_in),
    .reg_addr_out (reg_addr_out),
    .reg_we_out   (reg_we_out),
    .acc_we_out   (acc_we_out),
    .wb_sel_out   (wb_sel_out),
    .mem          (mif),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},     32'(pc_out), 0);
    chk({tag, "_alu_op"}, 32'(alu_op_out), 0);
    chk({tag, "_raddr"},  32'(reg_addr_out), 0);
    chk({tag, "_wes"},    32'({reg_we_out, acc_we_out, mif.mem_we_out}), 0);
    chk({tag, "_wb"},     32'(wb_sel_out), 0);
    chk({tag, "_req"},    32'(mif.mem_req_out), 0);
    chk({tag, "_done"},   32'(done_out), 0);
    chk({tag, "_err"},    32'(err_out), 0);
  endtask

  typedef struct {
    logic [8:0] ir;
    logic       zi;
    logic       chk_op;
    logic [2:0] op;
    logic       chk_addr;
    logic [3:0] addr;
    logic       reg_we;
    logic       acc_we;
    logic [1:0] wb;
    logic [7:0] pc_nxt;
  } vec_t;

  vec_t tbl[16];

  // instruction-level reference model state
  int  m_pc;
  bit  m_z;

  function automatic int sext6(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  initial begin
    int   req_cnt;
    logic [8:0] ir;
    logic zi;
    bit   is_alu, memop, halt, is_ld;
    int   d;

    rst_n = 1'b0; start = 1'b0; zero_in = 1'b0; inst_in = '0;
    mif.mem_ack_in = 1'b0;

    //          ir      zi    chkop op    chka  addr  rwe   awe   wb    pc
    tbl[0]  = '{9'h103, 1'b0, 1'b1, 3'd0, 1'b1, 4'd3, 1'b0, 1'b1, 2'd0, 8'd1};
    tbl[1]  = '{9'h135, 1'b1, 1'b1, 3'd1, 1'b1, 4'd5, 1'b1, 1'b0, 2'd0, 8'd2};
    tbl[2]  = '{9'h007, 1'b0, 1'b0, 3'd0, 1'b1, 4'd7, 1'b1, 1'b0, 2'd1, 8'd3};
    tbl[3]  = '{9'h049, 1'b0, 1'b0, 3'd0, 1'b1, 4'd9, 1'b0, 1'b1, 2'd2, 8'd4};
    tbl[4]  = '{9'h0BE, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd2};
    tbl[5]  = '{9'h120, 1'b0, 1'b1, 3'd1, 1'b1, 4'd0, 1'b0, 1'b1, 2'd0, 8'd3};
    tbl[6]  = '{9'h0BE, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd4};
    tbl[7]  = '{9'h1DF, 1'b0, 1'b1, 3'd6, 1'b1, 4'd15, 1'b1, 1'b0, 2'd0, 8'd5};
    tbl[8]  = '{9'h1E2, 1'b1, 1'b1, 3'd7, 1'b1, 4'd2, 1'b0, 1'b1, 2'd0, 8'd6};
    tbl[9]  = '{9'h151, 1'b1, 1'b1, 3'd2, 1'b1, 4'd1, 1'b1, 1'b0, 2'd0, 8'd7};
    tbl[10] = '{9'h085, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd8};
    tbl[11] = '{9'h120, 1'b1, 1'b1, 3'd1, 1'b1, 4'd0, 1'b0, 1'b1, 2'd0, 8'd9};
    tbl[12] = '{9'h080, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd9};
    tbl[13] = '{9'h083, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd12};
    tbl[14] = '{9'h0B3, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd255};
    tbl[15] = '{9'h081, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'd0};

    #1 chk_reset_vals("rst_held");
    do_reset();
    chk_reset_vals("rst_rel");
    pulse_start();

    for (int i = 0; i < 16; i++) begin
      inst_in = tbl[i].ir;
      zero_in = tbl[i].zi;
      @(posedge clk); @(negedge clk);
      if (tbl[i].chk_op)   chk($sformatf("v%0d_alu_op", i), 32'(alu_op_out), 32'(tbl[i].op));
      if (tbl[i].chk_addr) chk($sformatf("v%0d_raddr", i), 32'(reg_addr_out), 32'(tbl[i].addr));
      chk($sformatf("v%0d_reg_we", i), 32'(reg_we_out), 32'(tbl[i].reg_we));
      chk($sformatf("v%0d_acc_we", i), 32'(acc_we_out), 32'(tbl[i].acc_we));
      chk($sformatf("v%0d_wb", i),     32'(wb_sel_out), 32'(tbl[i].wb));
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_pc", i),     32'(pc_out), 32'(tbl[i].pc_nxt));
    end

    // LD with ack arriving on the 4th MEM cycle (pc 0)
    inst_in = 9'h0C4;
    @(posedge clk); @(negedge clk);
    chk("ld_exec_req", 32'(mif.mem_req_out), 0);
    chk("ld_exec_acc_we", 32'(acc_we_out), 0);
    req_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 3) begin
        mif.mem_ack_in = 1'b1;
        #1;
        chk("ld_ack_acc_we", 32'(acc_we_out), 1);
        chk("ld_ack_wb", 32'(wb_sel_out), 3);
      end else begin
        chk($sformatf("ld_wait%0d_acc_we", c), 32'(acc_we_out), 0);
      end
      if (mif.mem_req_out) req_cnt++;
    end
    @(posedge clk);
    #1 mif.mem_ack_in = 1'b0;
    @(negedge clk);
    if (mif.mem_req_out) req_cnt++;
    chk("ld_req_cycles", 32'(req_cnt), 4);
    chk("ld_pc", 32'(pc_out), 1);

    // HALT at pc 1 with zflag still set from the table
    inst_in = 9'h0D0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("halt_done", 32'(done_out), 1);
    chk("halt_wes", 32'({reg_we_out, acc_we_out, mif.mem_req_out}), 0);
    chk("halt_pc", 32'(pc_out), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_stays", 32'(done_out), 1);
    pulse_start();
    chk("restart_pc", 32'(pc_out), 0);
    chk("restart_done", 32'(done_out), 0);
    inst_in = 9'h084;  // BRZ +4 must fall through: zflag cleared by start
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("restart_zflag_clr", 32'(pc_out), 1);

    // Reset asserted in the middle of an ST
    inst_in = 9'h0E2;
    @(posedge clk); @(negedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("st_req_wait", 32'(mif.mem_req_out), 1);
    chk("st_we_wait", 32'(mif.mem_we_out), 1);
    rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid_mem");
    do_reset();
    pulse_start();

    // ST that never gets an ack
    inst_in = 9'h0E2;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);   // MEM entry
`ifdef MEM_TIMEOUT_EN
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("tmo_still_mem", 32'({mif.mem_req_out, done_out, err_out}), 32'b100);
    @(posedge clk); @(negedge clk);
    chk("tmo_halt", 32'({mif.mem_req_out, done_out, err_out}), 32'b011);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("tmo_err_sticky", 32'(err_out), 1);
    pulse_start();
    chk("tmo_err_clr", 32'({done_out, err_out}), 0);
    chk("tmo_restart_pc", 32'(pc_out), 0);
`else
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("noack_still_mem", 32'({mif.mem_req_out, done_out, err_out}), 32'b100);
`endif

    // Randomized instructions against the instruction-level model
    do_reset();
    pulse_start();
    m_pc = 0;
    m_z  = 1'b0;
    for (int n = 0; n < 250; n++) begin
      ir = 9'($urandom_range(0, 511));
      if (ir[8:6] == 3'b011 && ir[4] && $urandom_range(0, 7) != 0) ir[4] = 1'b0;
      zi = 1'($urandom_range(0, 1));
      is_alu = ir[8];
      memop  = (ir[8:6] == 3'b011) && !ir[4];
      halt   = (ir[8:6] == 3'b011) && ir[4];
      is_ld  = memop && !ir[5];
      inst_in = ir;
      zero_in = zi;
      mif.mem_ack_in = 1'($urandom_range(0, 1));   // stray acks are ignored
      start = 1'($urandom_range(0, 1));            // start in FETCH is ignored
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      mif.mem_ack_in = 1'($urandom_range(0, 1));
      #1;
      chk("r_exec_reg_we", 32'(reg_we_out), is_alu ? 32'(ir[4]) : 32'(ir[8:6] == 3'b000));
      chk("r_exec_acc_we", 32'(acc_we_out), is_alu ? 32'(!ir[4]) : 32'(ir[8:6] == 3'b001));
      if (!memop && !halt)
        chk("r_exec_wb", 32'(wb_sel_out),
            is_alu ? 0 : (ir[8:6] == 3'b000) ? 1 : (ir[8:6] == 3'b001) ? 2 : 0);
      if (is_alu) chk("r_exec_op", 32'(alu_op_out), 32'(ir[7:5]));
      if (ir[8:6] != 3'b010 && !halt) chk("r_exec_raddr", 32'(reg_addr_out), 32'(ir[3:0]));
      chk("r_exec_req", 32'({mif.mem_req_out, done_out, err_out}), 0);

      if (is_alu && ir[7:5] == 3'd1) m_z = zi;
      if (halt) begin
        @(posedge clk); @(negedge clk);
        mif.mem_ack_in = 1'b0;
        chk("r_halt_done", 32'(done_out), 1);
        chk("r_halt_pc", 32'(pc_out), 32'(m_pc));
        pulse_start();
        m_pc = 0;
        m_z  = 1'b0;
      end else if (memop) begin
        d = $urandom_range(0, 3);
        for (int c = 0; c <= d; c++) begin
          @(posedge clk); @(negedge clk);
          zero_in = 1'($urandom_range(0, 1));
          start = 1'($urandom_range(0, 1));
          mif.mem_ack_in = (c == d);
          #1;
          chk("r_mem_req", 32'(mif.mem_req_out), 1);
          chk("r_mem_we", 32'(mif.mem_we_out), 32'(!is_ld));
          chk("r_mem_acc_we", 32'(acc_we_out), 32'(is_ld && c == d));
          if (is_ld) chk("r_mem_wb", 32'(wb_sel_out), 3);
        end
        @(posedge clk);
        #1 mif.mem_ack_in = 1'b0;
        start = 1'b0;
        @(negedge clk);
        m_pc = (m_pc + 1) % 256;
      end else begin
        @(posedge clk); @(negedge clk);
        if (ir[8:6] == 3'b010 && m_z) m_pc = ((m_pc + sext6(ir[5:0])) % 256 + 256) % 256;
        else                          m_pc = (m_pc + 1) % 256;
      end
      mif.mem_ack_in = 1'b0;
      chk("r_pc", 32'(pc_out), 32'(m_pc));
      chk("r_fetch_done", 32'({done_out, err_out, mif.mem_req_out}), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
